// File: rtl/cic_pkg.sv
// Shared CIC helpers: width derivation, accumulator type and dither LFSR constants
// common to the interpolator and the decimator.
package cic_pkg;

  localparam int unsigned LfsrWidth = 15;
  localparam logic [LfsrWidth-1:0] LfsrSeed = 15'h0001;
  // x^15 + x^14 + 1 taps, Fibonacci form shifting towards the MSB
  localparam logic [LfsrWidth-1:0] LfsrTaps = 15'h6000;

  function automatic int unsigned calc_lg_r(int unsigned r);
    return $clog2(r);
  endfunction

  // Two integrator stages grow by lg_r bits each, plus sign and guard bit
  function automatic int unsigned calc_acc_width(int unsigned dw, int unsigned r);
    return dw + 2 * $clog2(r) + 2;
  endfunction

  localparam int unsigned DefaultAccWidth = calc_acc_width(16, 16);
  typedef logic signed [DefaultAccWidth-1:0] acc_t;

endpackage

// File: rtl/dsm1_mod.sv
// First-order 1-bit delta-sigma modulator; ones-density = level_i / 2^data_width.
// Define CIC2_INTERP_DITHER_EN to add an LFSR carry-in that breaks idle tones.
module dsm1_mod
  import cic_pkg::*;
#(
  parameter int unsigned data_width = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [data_width-1:0] level_i,
  output logic                  dsm_o
);

  logic [data_width-1:0] dacc_q;
  logic [data_width:0]   sum;
  logic                  cin;

`ifdef CIC2_INTERP_DITHER_EN
  logic [LfsrWidth-1:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= {lfsr_q[LfsrWidth-2:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  assign cin = lfsr_q[0];
`else
  assign cin = 1'b0;
`endif

  assign sum = {1'b0, dacc_q} + {1'b0, level_i} + {{data_width{1'b0}}, cin};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dacc_q <= '0;
      dsm_o  <= 1'b0;
    end else begin
      dacc_q <= sum[data_width-1:0];
      dsm_o  <= sum[data_width];
    end
  end

endmodule

// File: rtl/cic2_interp_dsm.sv
// 2nd-order CIC interpolator (combs at slot rate, integrators at clk rate) feeding a 1-bit DSM.
// Optional dither inside dsm1_mod is enabled with CIC2_INTERP_DITHER_EN.
module cic2_interp_dsm
  import cic_pkg::*;
#(
  parameter int unsigned data_width    = 16,
  parameter int unsigned interp_factor = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [data_width-1:0] sample_data_i,
  input  logic                  sample_valid_i,
  output logic                  sample_ready_o,
  output logic                  dsm_data_o,
  output logic                  underrun_o,
  output logic [data_width-1:0] level_o
);

  localparam int unsigned lg_r      = calc_lg_r(interp_factor);
  localparam int unsigned acc_width = calc_acc_width(data_width, interp_factor);

  typedef logic signed [acc_width-1:0] cic_acc_t;

  logic [lg_r-1:0]       phase_q;
  logic                  slot;
  logic [data_width-1:0] x_sel;
  logic [data_width-1:0] x_prev_q;
  logic                  underrun_q;
  cic_acc_t              x_ext, x_prev_ext, d1;
  cic_acc_t              comb1_q, comb2_q;
  cic_acc_t              int_in, int1_q, int2_q;
  logic                  unused_int2;

  // interp_factor is a power of two, so the last phase is all ones
  assign slot           = &phase_q;
  assign sample_ready_o = slot;

  // A missed slot repeats the previous sample, so the comb sees a zero difference
  assign x_sel      = sample_valid_i ? sample_data_i : x_prev_q;
  assign x_ext      = cic_acc_t'(x_sel);
  assign x_prev_ext = cic_acc_t'(x_prev_q);
  assign d1         = x_ext - x_prev_ext;

  // Zero-stuffing: comb output enters the integrators once per slot period
  assign int_in = (phase_q == '0) ? comb2_q : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      phase_q    <= '0;
      x_prev_q   <= '0;
      comb1_q    <= '0;
      comb2_q    <= '0;
      int1_q     <= '0;
      int2_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      phase_q    <= phase_q + lg_r'(1);
      underrun_q <= slot & ~sample_valid_i;
      if (slot) begin
        x_prev_q <= x_sel;
        comb1_q  <= d1;
        comb2_q  <= d1 - comb1_q;
      end
      // Modular wrap is intended; it cancels through the combs
      int1_q <= int1_q + int_in;
      int2_q <= int2_q + int1_q;
    end
  end

  // Dividing by R (drop lg_r LSBs) restores unity gain
  assign level_o     = int2_q[lg_r+data_width-1 -: data_width];
  assign unused_int2 = ^{int2_q[acc_width-1:lg_r+data_width], int2_q[lg_r-1:0]};
  assign underrun_o  = underrun_q;

  dsm1_mod #(
    .data_width(data_width)
  ) u_dsm (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .level_i(level_o),
    .dsm_o  (dsm_data_o)
  );

endmodule

// File: tb/tb_cic2_interp_dsm.sv
// Self-checking bench for cic2_interp_dsm: linear-interpolation reference model plus
// directed literal checks for slot timing, ramp, density, underrun and reset.
module tb_cic2_interp_dsm;

  localparam int DW = 16;
  localparam int R  = 16;
`ifdef CIC2_INTERP_DITHER_EN
  localparam bit Dither = 1'b1;
`else
  localparam bit Dither = 1'b0;
`endif
  localparam int HalfLo  = Dither ? 126 : 128;
  localparam int HalfHi  = Dither ? 130 : 128;
  localparam int ZeroMax = Dither ? 1 : 0;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [DW-1:0] sample_data_i = '0;
  logic          sample_valid_i = 1'b0;
  logic          sample_ready_o;
  logic          dsm_data_o;
  logic          underrun_o;
  logic [DW-1:0] level_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cic2_interp_dsm #(
    .data_width   (DW),
    .interp_factor(R)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .sample_data_i (sample_data_i),
    .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o),
    .dsm_data_o    (dsm_data_o),
    .underrun_o    (underrun_o),
    .level_o       (level_o)
  );

  // Reference model state: cycle count since reset, sample played in each slot
  int     cnt = 0;
  int     samples[$];
  longint macc = 0;
  longint m_lvl, m_sum;
  int     m_last;
  bit     exp_dsm = 1'b0;
  bit     exp_und = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cnt, act, exp);
    end
  endtask

  // Level during cycle c: straight line from sample k-1 to sample k over R cycles
  function automatic longint model_level(input int c);
    int     m, k, n;
    longint prev, cur;
    if (c <= R) return 0;
    m    = c - R - 1;
    k    = m / R;
    n    = m % R;
    cur  = samples[k];
    prev = (k > 0) ? samples[k-1] : 0;
    return ((R - n) * prev + n * cur) / R;
  endfunction

  initial begin
    forever begin
      @(posedge clk_i or negedge rstn_i);
      if (!rstn_i) begin
        cnt = 0;
        samples.delete();
        macc    = 0;
        exp_dsm = 1'b0;
        exp_und = 1'b0;
      end else begin
        m_lvl   = model_level(cnt);
        exp_und = 1'b0;
        if (cnt % R == R - 1) begin
          m_last = (samples.size() > 0) ? samples[$] : 0;
          samples.push_back(sample_valid_i ? int'(sample_data_i) : m_last);
          exp_und = !sample_valid_i;
        end
        m_sum   = macc + m_lvl;
        exp_dsm = m_sum[DW];
        macc    = m_sum & 64'hFFFF;
        cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      chk("ready", sample_ready_o, (cnt % R == R - 1));
      chk("level", level_o, model_level(cnt));
      chk("underrun", underrun_o, exp_und);
`ifndef CIC2_INTERP_DITHER_EN
      chk("dsm", dsm_data_o, exp_dsm);
`endif
    end
  end

  // New data only at phase 0, i.e. after the previous slot has taken its sample
  task automatic hold(input int n, input logic [DW-1:0] v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (cnt % R == 0) begin
        sample_data_i  = v;
        sample_valid_i = 1'b1;
      end
    end
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      ones += int'(dsm_data_o);
    end
  endtask

  task automatic random_run(input int n);
    int pick;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (cnt % R == 0) begin
        pick = $urandom_range(9);
        sample_data_i  = (pick == 0) ? 16'h0000 : (pick == 1) ? 16'hFFFF : DW'($urandom);
        sample_valid_i = ($urandom_range(7) != 0);
      end
    end
  endtask

  initial begin
    int first_ready;
    int ones;
    int und_cnt;
    int lv_min, lv_max;

    repeat (3) @(negedge clk_i);
    chk("reset_level", level_o, 0);
    chk("reset_dsm", dsm_data_o, 0);
    chk("reset_underrun", underrun_o, 0);
    #2 rstn_i = 1'b1;

    // Step 0 -> 0x4000 with valid held from reset release
    sample_valid_i = 1'b1;
    sample_data_i  = 16'h4000;
    first_ready    = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (sample_ready_o && first_ready < 0) first_ready = cnt;
      if (cnt == 17) chk("step_lvl17", level_o, 16'h0000);
      if (cnt == 18) chk("step_lvl18", level_o, 16'h0400);
      if (cnt == 25) chk("step_lvl25", level_o, 16'h2000);
      if (cnt == 33) chk("step_lvl33", level_o, 16'h4000);
      if (cnt == 40) chk("step_lvl40", level_o, 16'h4000);
    end
    chk("first_ready_cycle", first_ready, 15);

    hold(100, 16'h8000);
    count_ones(256, ones);
    chk("half_ones_in_range", (ones >= HalfLo) && (ones <= HalfHi), 1);

    // One missed slot at steady 0x2000
    hold(80, 16'h2000);
    while (cnt % R != 0) @(negedge clk_i);
    sample_valid_i = 1'b0;
    und_cnt = 0;
    lv_min  = 32'h7FFFFFFF;
    lv_max  = 0;
    for (int i = 0; i < 3 * R; i++) begin
      @(negedge clk_i);
      if (cnt % R == 0) sample_valid_i = 1'b1;
      und_cnt += int'(underrun_o);
      if (int'(level_o) < lv_min) lv_min = int'(level_o);
      if (int'(level_o) > lv_max) lv_max = int'(level_o);
    end
    chk("underrun_pulses", und_cnt, 1);
    chk("underrun_level_min", lv_min, 16'h2000);
    chk("underrun_level_max", lv_max, 16'h2000);

    hold(80, 16'h0000);
    count_ones(4096, ones);
    chk("zero_ones_bounded", ones <= ZeroMax, 1);

    hold(80, 16'hFFFF);
    count_ones(4096, ones);
    chk("full_ones_at_least", ones >= 4095, 1);

    random_run(3000);

    // Reset in the middle of a 0 -> 0x7000 ramp
    hold(64, 16'h0000);
    while (cnt % R != 0) @(negedge clk_i);
    sample_data_i = 16'h7000;
    repeat (R + 8) @(negedge clk_i);
    chk("mid_ramp_level", level_o, 16'h3100);
    #2 rstn_i = 1'b0;
    #1;
    chk("rst_level", level_o, 0);
    chk("rst_dsm", dsm_data_o, 0);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_ready", sample_ready_o, 0);
    repeat (3) @(negedge clk_i);
    #2 rstn_i = 1'b1;

    random_run(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
